// File: rtl/rv32_imm_core.sv
// Multi-cycle RV32I OP/OP-IMM core: fetch, decode, execute and write-back take one cycle each.
// Each instruction retires every 4 cycles. There is no backpressure; the instruction port is sampled only in FETCH.
module rv32_imm_core #(
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic [31:0] PC_out,
    output logic [7:0]  LED
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_res;
    logic [7:0]  r_led;
    logic [31:0] r_regs [32];

    logic        w_ir_ld;
    logic        w_opnd_ld;
    logic        w_res_ld;
    logic        w_wb;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_alt;
    logic        w_is_op;
    logic        w_is_opimm;
    logic [31:0] w_opb;
    logic [4:0]  w_shamt;
    logic signed [31:0] w_sra;
    logic [31:0] w_alu;

    assign w_opcode   = r_ir[6:0];
    assign w_rd       = r_ir[11:7];
    assign w_funct3   = r_ir[14:12];
    assign w_rs1      = r_ir[19:15];
    assign w_rs2      = r_ir[24:20];
    assign w_alt      = r_ir[30];
    assign w_is_opimm = (w_opcode == 7'b0010011);
    assign w_is_op    = (w_opcode == 7'b0110011);

    // OP takes its second operand and shift amount from rs2; OP-IMM from the immediate field.
    assign w_opb   = w_is_op ? r_b : r_imm;
    assign w_shamt = w_is_op ? r_b[4:0] : r_ir[24:20];
    assign w_sra   = $signed(r_a) >>> w_shamt;

    always_ff @(posedge clk) begin
        if (rst_n) r_state <= S_FETCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ir_ld     = 1'b0;
        w_opnd_ld   = 1'b0;
        w_res_ld    = 1'b0;
        w_wb        = 1'b0;
        case (r_state)
            S_FETCH:     begin w_ir_ld   = 1'b1; w_state_nxt = S_DECODE;    end
            S_DECODE:    begin w_opnd_ld = 1'b1; w_state_nxt = S_EXECUTE;   end
            S_EXECUTE:   begin w_res_ld  = 1'b1; w_state_nxt = S_WRITEBACK; end
            S_WRITEBACK: begin w_wb      = 1'b1; w_state_nxt = S_FETCH;     end
            default:     w_state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (w_funct3)
            3'b000: w_alu = (w_is_op && w_alt) ? (r_a - w_opb) : (r_a + w_opb);
            3'b001: w_alu = r_a << w_shamt;
            3'b010: w_alu = {31'b0, ($signed(r_a) < $signed(w_opb))};
            3'b011: w_alu = {31'b0, (r_a < w_opb)};
            3'b100: w_alu = r_a ^ w_opb;
            3'b101: begin
                if (w_alt) w_alu = w_sra;
                else       w_alu = r_a >> w_shamt;
            end
            3'b110: w_alu = r_a | w_opb;
            3'b111: w_alu = r_a & w_opb;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_res <= '0;
            r_led <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            if (w_ir_ld) r_ir <= instruction;
            if (w_opnd_ld) begin
                r_a   <= (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
                r_b   <= (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
                r_imm <= {{20{r_ir[31]}}, r_ir[31:20]};
            end
            if (w_res_ld) r_res <= w_alu;
            if (w_wb) begin
                r_pc <= r_pc + PC_STEP;
                // Unsupported opcodes retire as NOPs; x0 stays hard-wired to zero.
                if ((w_is_op || w_is_opimm) && (w_rd != 5'd0)) begin
                    r_regs[w_rd] <= r_res;
                    r_led        <= r_res[7:0];
                end
            end
        end
    end

    assign PC_out = r_pc;
    assign LED    = r_led;

endmodule

// File: tb/tb_rv32_imm_core.sv
// Directed-vector bench for rv32_imm_core: retires hand-encoded instructions and checks PC, LED and registers.
module tb_rv32_imm_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] PC_out;
    logic [7:0]  LED;

    int          n_vec;
    int          n_miss;
    logic [31:0] exp_pc;

    rv32_imm_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .PC_out      (PC_out),
        .LED         (LED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the FSM in FETCH; waits (bounded) for the PC to step.
    task automatic run_instr(input logic [31:0] instr, input string tag);
        logic [31:0] pc0;
        int          cyc;
        instruction = instr;
        pc0 = PC_out;
        cyc = 0;
        while (PC_out == pc0 && cyc < 8) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        exp_pc = exp_pc + 32'd4;
        chk({tag, "_pc"}, PC_out, exp_pc);
        chk({tag, "_cycles"}, 32'(cyc), 32'd4);
    endtask

    logic [31:0] seq_ins [7] = '{32'h0C600E93, 32'h04CF4A13, 32'h0CB3C793, 32'h02B36613,
                                 32'h0ACFE993, 32'h015A7493, 32'h073EFC93};
    int          seq_rd  [7] = '{29, 20, 15, 12, 19, 9, 25};
    logic [31:0] seq_val [7] = '{32'd198, 32'd76, 32'd203, 32'd43, 32'd172, 32'd4, 32'd66};

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        exp_pc      = 32'd0;
        rst_n       = 1'b1;
        instruction = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pc",  PC_out, 32'h0);
        chk("reset_led", {24'h0, LED}, 32'h0);
        chk("reset_x3",  dut.r_regs[3], 32'h0);

        // ADDI x3,x13,34 held on the port; PC steps on the 4th edge only.
        instruction = 32'h02268193;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pc_before_4th_edge", PC_out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        exp_pc = 32'd4;
        chk("addi_pc",  PC_out, 32'd4);
        chk("addi_x3",  dut.r_regs[3], 32'd34);
        chk("addi_led", {24'h0, LED}, 32'h22);

        for (int i = 0; i < 7; i++) begin
            run_instr(seq_ins[i], "seq");
            chk("seq_led", {24'h0, LED}, {24'h0, seq_val[i][7:0]});
        end
        for (int i = 0; i < 7; i++) chk("seq_reg", dut.r_regs[seq_rd[i]], seq_val[i]);
        chk("seq_final_led", {24'h0, LED}, 32'h42);

        run_instr(32'hFFF00093, "addi_m1");
        chk("x1_m1",   dut.r_regs[1], 32'hFFFFFFFF);
        chk("led_m1",  {24'h0, LED}, 32'hFF);
        run_instr(32'h4040D113, "srai");
        chk("srai_x2", dut.r_regs[2], 32'hFFFFFFFF);
        run_instr(32'h0040D113, "srli");
        chk("srli_x2", dut.r_regs[2], 32'h0FFFFFFF);

        run_instr(32'h40110333, "sub");
        chk("sub_x6",  dut.r_regs[6], 32'h10000000);
        chk("sub_led", {24'h0, LED}, 32'h00);
        run_instr(32'h0000A3B3, "slt");
        chk("slt_x7",  dut.r_regs[7], 32'h1);
        run_instr(32'h00103433, "sltu");
        chk("sltu_x8", dut.r_regs[8], 32'h1);
        chk("sltu_led", {24'h0, LED}, 32'h01);

        run_instr(32'h00500013, "addi_x0");
        chk("x0_zero",    dut.r_regs[0], 32'h0);
        chk("x0_led_kept", {24'h0, LED}, 32'h01);

        run_instr(32'h00000000, "nop");
        chk("nop_led_kept", {24'h0, LED}, 32'h01);
        chk("nop_x1_kept",  dut.r_regs[1], 32'hFFFFFFFF);

        // Reset lands while ADDI x5,x0,9 is in EXECUTE.
        instruction = 32'h00900293;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_exec_x5",  dut.r_regs[5], 32'h0);
        chk("rst_exec_pc",  PC_out, 32'h0);
        chk("rst_exec_led", {24'h0, LED}, 32'h0);
        chk("rst_exec_x1",  dut.r_regs[1], 32'h0);
        rst_n  = 1'b0;
        exp_pc = 32'd0;
        run_instr(32'h00900293, "restart");
        chk("restart_x5",  dut.r_regs[5], 32'd9);
        chk("restart_led", {24'h0, LED}, 32'h09);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
